alu_host_seq: RTL and testbench

Initiator for the ALU's serial operand protocol (BEGIN / op_code / inbus in, outbus / END back).
Accepts one operation request as a valid/ready transaction, streams operands A then B into the ALU and waits for END. Captures the 8- or 16-bit result and returns it on a valid/ready response channel.
Sits between a command source (CPU stub, test sequencer) and the alu block, replacing hand-timed stimulus.

---
 rtl/alu_host_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_host_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_host_seq.sv
// Host-side sequencer for the serial ALU protocol: takes one request, streams A/B, returns the result.
// Optional feature macro: ALU_HOST_TIMEOUT_EN (abort WAIT_END after TIMEOUT_CYCLES with rsp_err=1).
module alu_host_seq #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        BEGIN,
  output logic [1:0]  op_code,
  output logic [7:0]  inbus,
  input  logic [7:0]  outbus,
  input  logic        END,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START, SEND_A, SEND_B, WAIT_END, CAP_LO, RESP
  } state_t;

  if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("alu_host_seq: TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state, state_next;
  logic [1:0]  op_q, op_next;
  logic [7:0]  a_q, a_next, b_q, b_next;
  logic        begin_next;
  logic [1:0]  op_code_next;
  logic [7:0]  inbus_next;
  logic        rsp_valid_next;
  logic [15:0] rsp_data_next;
  logic        rsp_err_next;

`ifdef ALU_HOST_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt, to_cnt_next;
`endif

  // Reset is folded in so the host never advertises readiness while held in reset.
  assign req_ready = reset && (state == IDLE);
  assign busy      = (state != IDLE);

  // ALU-facing and response outputs are computed for the state being entered, then registered.
  always_comb begin
    state_next     = state;
    op_next        = op_q;
    a_next         = a_q;
    b_next         = b_q;
    begin_next     = 1'b0;
    op_code_next   = op_code;
    inbus_next     = 8'h00;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    rsp_err_next   = 1'b0;
`ifdef ALU_HOST_TIMEOUT_EN
    rsp_err_next   = rsp_err;
    to_cnt_next    = to_cnt;
`endif
    case (state)
      IDLE: begin
        op_code_next = 2'b00;
        if (req_valid) begin
          op_next      = req_op;
          a_next       = req_a;
          b_next       = req_b;
          state_next   = START;
          begin_next   = 1'b1;
          op_code_next = req_op;
        end
      end
      START: begin
        state_next = SEND_A;
        begin_next = 1'b1;
        inbus_next = a_q;
      end
      SEND_A: begin
        state_next = SEND_B;
        inbus_next = b_q;
      end
      SEND_B: begin
        state_next = WAIT_END;
`ifdef ALU_HOST_TIMEOUT_EN
        to_cnt_next = '0;
`endif
      end
      WAIT_END: begin
        if (END) begin
          rsp_err_next = 1'b0;
          if (op_q[1]) begin
            state_next           = CAP_LO;
            rsp_data_next[15:8]  = outbus;
          end else begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = {8'h00, outbus};
          end
        end
`ifdef ALU_HOST_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = 16'h0000;
          rsp_err_next   = 1'b1;
        end else begin
          to_cnt_next = to_cnt + 1'b1;
        end
`endif
      end
      CAP_LO: begin
        state_next          = RESP;
        rsp_valid_next      = 1'b1;
        rsp_data_next[7:0]  = outbus;
        rsp_err_next        = 1'b0;
      end
      RESP: begin
        rsp_valid_next = 1'b1;
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          op_code_next   = 2'b00;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        op_code_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      BEGIN     <= 1'b0;
      op_code   <= 2'b00;
      inbus     <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
    end else begin
      state     <= state_next;
      op_q      <= op_next;
      a_q       <= a_next;
      b_q       <= b_next;
      BEGIN     <= begin_next;
      op_code   <= op_code_next;
      inbus     <= inbus_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
    end
  end

`ifdef ALU_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt  <= '0;
      rsp_err <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_next;
      rsp_err <= rsp_err_next;
    end
  end
`else
  assign rsp_err = 1'b0;
  logic unused_err;
  assign unused_err = rsp_err_next;
`endif

endmodule

// File: tb/tb_alu_host_seq.sv
// Directed self-checking bench for alu_host_seq; the bench plays the ALU side by hand.
module tb_alu_host_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        BEGIN;
  logic [1:0]  op_code;
  logic [7:0]  inbus;
  logic [7:0]  outbus;
  logic        END;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_host_seq #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .BEGIN(BEGIN), .op_code(op_code), .inbus(inbus),
    .outbus(outbus), .END(END), .busy(busy)
  );

  // Drive a request, walk every protocol phase and check outputs on each falling edge.
  task automatic do_op(input string name, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int n, input logic [7:0] hi,
                       input logic [7:0] lo, input logic [15:0] exp, input int stall,
                       input bit end_early);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s idle_ready got=%b want=1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (end_early) begin END = 1'b1; outbus = hi; end
    total++;
    if ({BEGIN, inbus, op_code, busy, req_ready} !== {1'b1, 8'h00, op, 1'b1, 1'b0}) begin
      bad++; $display("FAIL %s start got=%b/%h/%b/%b/%b want=1/00/%b/1/0",
                      name, BEGIN, inbus, op_code, busy, req_ready, op);
    end
    @(negedge clk);
    total++;
    if ({BEGIN, inbus, op_code} !== {1'b1, a, op}) begin
      bad++; $display("FAIL %s send_a got=%b/%h/%b want=1/%h/%b", name, BEGIN, inbus, op_code, a, op);
    end
    @(negedge clk);
    total++;
    if ({BEGIN, inbus, op_code} !== {1'b0, b, op}) begin
      bad++; $display("FAIL %s send_b got=%b/%h/%b want=0/%h/%b", name, BEGIN, inbus, op_code, b, op);
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      total++;
      if ({BEGIN, inbus, op_code, rsp_valid} !== {1'b0, 8'h00, op, 1'b0}) begin
        bad++; $display("FAIL %s wait%0d got=%b/%h/%b/%b want=0/00/%b/0",
                        name, i, BEGIN, inbus, op_code, rsp_valid, op);
      end
      END    = (i == n);
      outbus = (i == n) ? (op[1] ? hi : lo) : 8'h5A;
    end
    if (op[1]) begin
      @(negedge clk);
      END = 1'b0; outbus = lo;
      total++;
      if ({op_code, rsp_valid} !== {op, 1'b0}) begin
        bad++; $display("FAIL %s cap_lo got=%b/%b want=%b/0", name, op_code, rsp_valid, op);
      end
    end
    @(negedge clk);
    END = 1'b0; outbus = 8'hC3;
    for (int k = 0; k <= stall; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if ({rsp_valid, rsp_data, rsp_err, req_ready, BEGIN} !== {1'b1, exp, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL %s resp%0d got=%b/%h/%b/%b/%b want=1/%h/0/0/0",
                        name, k, rsp_valid, rsp_data, rsp_err, req_ready, BEGIN, exp);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready, busy, op_code} !== {1'b0, 1'b1, 1'b0, 2'b00}) begin
      bad++; $display("FAIL %s after_hs got=%b/%b/%b/%b want=0/1/0/00",
                      name, rsp_valid, req_ready, busy, op_code);
    end
  endtask

  // Push a request up to the first WAIT_END cycle without any output checks.
  task automatic reach_wait(input logic [1:0] op);
    @(negedge clk);
    req_op = op; req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00;
    rsp_ready = 1'b0; outbus = 8'h00; END = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({BEGIN, op_code, inbus, rsp_valid, rsp_data, rsp_err, busy} !== 30'h0) begin
      bad++; $display("FAIL reset_state got=%b/%b/%h/%b/%h/%b/%b want=all0",
                      BEGIN, op_code, inbus, rsp_valid, rsp_data, rsp_err, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_add();
    do_op("add", 2'b00, 8'd56, 8'd89, 3, 8'h00, 8'h91, 16'h0091, 0, 1'b0);
  endtask

  task automatic test_sub();
    do_op("sub", 2'b01, 8'd56, 8'd89, 3, 8'h00, 8'hDF, 16'h00DF, 0, 1'b0);
  endtask

  task automatic test_mul();
    do_op("mul", 2'b10, 8'd7, 8'd3, 3, 8'h00, 8'h15, 16'h0015, 0, 1'b0);
  endtask

  task automatic test_div();
    do_op("div", 2'b11, 8'd200, 8'd7, 2, 8'h1C, 8'h04, 16'h1C04, 0, 1'b0);
  endtask

  task automatic test_end_early();
    do_op("end_early", 2'b00, 8'h0F, 8'hF0, 1, 8'h00, 8'hFF, 16'h00FF, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    do_op("backpressure", 2'b01, 8'hA0, 8'h20, 2, 8'h00, 8'h80, 16'h0080, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen_valid = 1'b0;
    reach_wait(2'b10);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({BEGIN, op_code, inbus, rsp_valid, busy, rsp_err} !== 14'h0) begin
      bad++; $display("FAIL reset_mid_async got=%b/%b/%h/%b/%b/%b want=all0",
                      BEGIN, op_code, inbus, rsp_valid, busy, rsp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    total++;
    if (seen_valid) begin
      bad++; $display("FAIL reset_mid_no_rsp got=activity want=idle");
    end
    do_op("after_reset", 2'b00, 8'd1, 8'd2, 2, 8'h00, 8'h03, 16'h0003, 0, 1'b0);
  endtask

  task automatic test_timeout();
    reach_wait(2'b00);
`ifdef ALU_HOST_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_early got=%b want=0", rsp_valid);
    end
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
      bad++; $display("FAIL timeout_rsp got=%b/%b/%h want=1/1/0000", rsp_valid, rsp_err, rsp_data);
    end
    END = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    END = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, rsp_valid, req_ready} !== 3'b001) begin
      bad++; $display("FAIL timeout_late_end got=%b/%b/%b want=0/0/1", busy, rsp_valid, req_ready);
    end
`else
    repeat (40) @(negedge clk);
    total++;
    if ({busy, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL no_timeout_busy got=%b/%b want=1/0", busy, rsp_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, req_ready} !== 2'b01) begin
      bad++; $display("FAIL no_timeout_recover got=%b/%b want=0/1", busy, req_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_end_early();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
